// File: rtl/wci_axi_target_regfile.sv
// AXI4-Lite target backed by a byte-enabled register file (ID, write counter, R/W).
// Define WCI_AXI_PROT_CHECK_EN to reject unprivileged (PROT[0]=0) accesses.
module wci_axi_target_regfile #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h5743_4930
) (
  input  logic        wciS0_ACLK,
  input  logic        wciS0_ARESETn,
  input  logic        wciS0_AWVALID,
  output logic        wciS0_AWREADY,
  input  logic [31:0] wciS0_AWADDR,
  input  logic [2:0]  wciS0_AWPROT,
  input  logic        wciS0_WVALID,
  output logic        wciS0_WREADY,
  input  logic [31:0] wciS0_WDATA,
  input  logic [3:0]  wciS0_WSTRB,
  output logic        wciS0_BVALID,
  input  logic        wciS0_BREADY,
  output logic [1:0]  wciS0_BRESP,
  input  logic        wciS0_ARVALID,
  output logic        wciS0_ARREADY,
  input  logic [31:0] wciS0_ARADDR,
  input  logic [2:0]  wciS0_ARPROT,
  output logic        wciS0_RVALID,
  input  logic        wciS0_RREADY,
  output logic [31:0] wciS0_RDATA,
  output logic [1:0]  wciS0_RRESP
);

  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic        aw_held_q, aw_held_d;
  logic [29:0] awword_q, awword_d;
  logic [2:0]  awprot_q, awprot_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [29:0] wr_word, rd_word;
  logic [2:0]  wr_prot;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ok, rd_in_range;
  logic        wr_prot_ok, rd_prot_ok;
  logic        unused_ok;

  assign wciS0_AWREADY = wciS0_ARESETn && !aw_held_q && !bvalid_q;
  assign wciS0_WREADY  = wciS0_ARESETn && !w_held_q && !bvalid_q;
  assign wciS0_ARREADY = wciS0_ARESETn && !rvalid_q;
  assign wciS0_BVALID  = bvalid_q;
  assign wciS0_BRESP   = bresp_q;
  assign wciS0_RVALID  = rvalid_q;
  assign wciS0_RDATA   = rdata_q;
  assign wciS0_RRESP   = rresp_q;

  assign aw_hs = wciS0_AWVALID && wciS0_AWREADY;
  assign w_hs  = wciS0_WVALID && wciS0_WREADY;
  assign ar_hs = wciS0_ARVALID && wciS0_ARREADY;

  assign wr_word = aw_held_q ? awword_q : wciS0_AWADDR[31:2];
  assign wr_prot = aw_held_q ? awprot_q : wciS0_AWPROT;
  assign wr_data = w_held_q ? wdata_q : wciS0_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : wciS0_WSTRB;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign rd_word = wciS0_ARADDR[31:2];

`ifdef WCI_AXI_PROT_CHECK_EN
  assign wr_prot_ok = wr_prot[0];
  assign rd_prot_ok = wciS0_ARPROT[0];
`else
  assign wr_prot_ok = 1'b1;
  assign rd_prot_ok = 1'b1;
`endif

  assign wr_ok = ({2'b00, wr_word} < NUM_REGS) && (wr_word >= 30'd2)
                 && wr_prot_ok;
  assign rd_in_range = ({2'b00, rd_word} < NUM_REGS) && rd_prot_ok;

  assign unused_ok = ^{wciS0_AWADDR[1:0], wciS0_ARADDR[1:0],
                       wciS0_AWPROT, wciS0_ARPROT, wr_prot};

  // Write path: capture slots, commit on second handshake, B response, counter
  always_comb begin
    aw_held_d = aw_held_q;
    awword_d  = awword_q;
    awprot_d  = awprot_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awword_d  = wciS0_AWADDR[31:2];
      awprot_d  = wciS0_AWPROT;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wciS0_WDATA;
      wstrb_d  = wciS0_WSTRB;
    end
    if (bvalid_q && wciS0_BREADY) begin
      bvalid_d = 1'b0;
      if (bresp_q == RESP_OKAY) begin
        regs_d[1] = regs_q[1] + 32'd1;
      end
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) begin
            regs_d[wr_word[IW-1:0]][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read path: registered response from pre-edge register contents
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && wciS0_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (!rd_in_range) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (rd_word == 30'd0) begin
        rdata_d = ID_VALUE;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = regs_q[rd_word[IW-1:0]];
        rresp_d = RESP_OKAY;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge wciS0_ACLK) begin
    if (!wciS0_ARESETn) begin
      aw_held_q <= 1'b0;
      awword_q  <= '0;
      awprot_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_held_q <= aw_held_d;
      awword_q  <= awword_d;
      awprot_q  <= awprot_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_wci_axi_target_regfile.sv
// Scoreboard bench for wci_axi_target_regfile.
// Expected B/R responses are queued at issue and checked at handshake.
module tb_wci_axi_target_regfile;

  localparam logic [31:0] ID = 32'h5743_4930;
  localparam logic [1:0]  OK = 2'b00;
  localparam logic [1:0]  SE = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int tests = 0;
  int fails = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  always #5 clk = ~clk;

  wci_axi_target_regfile dut (
    .wciS0_ACLK(clk), .wciS0_ARESETn(rst_n),
    .wciS0_AWVALID(awvalid), .wciS0_AWREADY(awready),
    .wciS0_AWADDR(awaddr), .wciS0_AWPROT(awprot),
    .wciS0_WVALID(wvalid), .wciS0_WREADY(wready),
    .wciS0_WDATA(wdata), .wciS0_WSTRB(wstrb),
    .wciS0_BVALID(bvalid), .wciS0_BREADY(bready),
    .wciS0_BRESP(bresp),
    .wciS0_ARVALID(arvalid), .wciS0_ARREADY(arready),
    .wciS0_ARADDR(araddr), .wciS0_ARPROT(arprot),
    .wciS0_RVALID(rvalid), .wciS0_RREADY(rready),
    .wciS0_RDATA(rdata), .wciS0_RRESP(rresp)
  );

  // scoreboard: compare each B/R handshake with the oldest expectation
  always @(negedge clk) begin
    if (bvalid && bready) begin
      tests++;
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected: got bresp %b, none queued", bresp);
      end else begin
        logic [1:0] eb;
        eb = bq.pop_front();
        if (bresp !== eb) begin
          fails++;
          $display("FAIL bresp: got %b expected %b", bresp, eb);
        end
      end
    end
    if (rvalid && rready) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL r_unexpected: got %b/%h, none queued", rresp, rdata);
      end else begin
        logic [33:0] er;
        er = rq.pop_front();
        if ({rresp, rdata} !== er) begin
          fails++;
          $display("FAIL rdata: got %b/%h expected %b/%h",
                   rresp, rdata, er[33:32], er[31:0]);
        end
      end
    end
  end

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s_timeout: no handshake within budget", nm);
  endtask

  task automatic hs_aw(input logic [31:0] a, input logic [2:0] p);
    logic hit;
    awaddr = a; awprot = p; awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); hit = awready;
      @(posedge clk); #1;
      if (hit) begin awvalid = 1'b0; return; end
    end
    awvalid = 1'b0;
    timeout("aw");
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
    logic hit;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); hit = wready;
      @(posedge clk); #1;
      if (hit) begin wvalid = 1'b0; return; end
    end
    wvalid = 1'b0;
    timeout("w");
  endtask

  task automatic hs_ar(input logic [31:0] a, input logic [2:0] p);
    logic hit;
    araddr = a; arprot = p; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); hit = arready;
      @(posedge clk); #1;
      if (hit) begin arvalid = 1'b0; return; end
    end
    arvalid = 1'b0;
    timeout("ar");
  endtask

  task automatic wait_b(output int lat);
    logic hit;
    bready = 1'b1; lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); lat++; hit = bvalid;
      @(posedge clk); #1;
      if (hit) begin bready = 1'b0; return; end
    end
    bready = 1'b0;
    timeout("b");
  endtask

  task automatic wait_r(output int lat);
    logic hit;
    rready = 1'b1; lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); lat++; hit = rvalid;
      @(posedge clk); #1;
      if (hit) begin rready = 1'b0; return; end
    end
    rready = 1'b0;
    timeout("r");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
    int lat;
    bq.push_back(er);
    fork
      hs_aw(a, 3'b001);
      hs_w(d, s);
    join
    wait_b(lat);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed,
                         input logic [1:0] er);
    int lat;
    rq.push_back({er, ed});
    hs_ar(a, 3'b001);
    wait_r(lat);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL r_latency: got %0d expected 1", lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}
          !== 41'd0) begin
        fails++;
        $display("FAIL reset_outputs: got %b/%b/%b %b/%b %b/%b %h expected 0",
                 awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++;
      $display("FAIL ready_after_reset: got %b expected 111",
               {awready, wready, arready});
    end
    @(posedge clk); #1;
    do_read(32'h0, ID, OK);
  endtask

  task automatic test_same_cycle();
    int lat;
    bq.push_back(OK);
    fork
      hs_aw(32'h8, 3'b001);
      hs_w(32'hDEAD_BEEF, 4'hF);
    join
    wait_b(lat);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL b_latency: got %0d expected 1", lat);
    end
    do_read(32'h8, 32'hDEAD_BEEF, OK);
    do_read(32'h4, 32'd1, OK);
  endtask

  task automatic test_w_first();
    int lat;
    bq.push_back(OK);
    hs_w(32'h1122_3344, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({wready, bvalid} !== 2'b00) begin
        fails++;
        $display("FAIL wready_held: got %b expected 00", {wready, bvalid});
      end
      @(posedge clk); #1;
    end
    hs_aw(32'h8, 3'b001);
    wait_b(lat);
    do_read(32'h8, 32'hDE22_BE44, OK);
    do_read(32'h4, 32'd2, OK);
  endtask

  task automatic test_backpressure();
    int lb, lr;
    bq.push_back(OK);
    rq.push_back({OK, 32'hDE22_BE44});
    fork
      hs_aw(32'h10, 3'b001);
      hs_w(32'hCAFE_F00D, 4'hF);
      hs_ar(32'h8, 3'b001);
    join
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready}
          !== {1'b1, OK, 1'b1, OK, 32'hDE22_BE44, 3'b000}) begin
        fails++;
        $display("FAIL hold_stable: got %b%b %b%b %h rdy %b",
                 bvalid, bresp, rvalid, rresp, rdata,
                 {awready, wready, arready});
      end
      @(posedge clk); #1;
    end
    fork
      wait_b(lb);
      wait_r(lr);
    join
    @(negedge clk);
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++;
      $display("FAIL ready_release: got %b expected 111",
               {awready, wready, arready});
    end
    @(posedge clk); #1;
    do_read(32'h10, 32'hCAFE_F00D, OK);
    do_read(32'h4, 32'd3, OK);
  endtask

  task automatic test_errors();
    do_write(32'h0, 32'hFFFF_FFFF, 4'hF, SE);
    do_write(32'h4, 32'hFFFF_FFFF, 4'hF, SE);
    do_write(32'h40, 32'h1234_5678, 4'hF, SE);
    do_read(32'h4, 32'd3, OK);
    do_read(32'h40, 32'd0, SE);
    do_read(32'h0, ID, OK);
    do_write(32'h10, 32'h0, 4'h0, OK);
    do_read(32'h10, 32'hCAFE_F00D, OK);
    do_read(32'h4, 32'd4, OK);
  endtask

  task automatic test_collision();
    int lb, lr;
    bq.push_back(OK);
    rq.push_back({OK, 32'h0});
    fork
      hs_aw(32'hC, 3'b001);
      hs_w(32'h5, 4'hF);
      hs_ar(32'hC, 3'b001);
    join
    fork
      wait_b(lb);
      wait_r(lr);
    join
    do_read(32'hC, 32'h5, OK);
    do_read(32'h4, 32'd5, OK);
  endtask

  task automatic test_mid_reset();
    int lat;
    hs_aw(32'h8, 3'b001);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({awready, wready, arready, bvalid} !== 4'b0000) begin
        fails++;
        $display("FAIL mid_reset_outputs: got %b expected 0000",
                 {awready, wready, arready, bvalid});
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    do_read(32'h8, 32'h0, OK);
    do_read(32'h4, 32'h0, OK);
    hs_w(32'h99, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (bvalid !== 1'b0) begin
        fails++;
        $display("FAIL dropped_aw: got bvalid %b expected 0", bvalid);
      end
      @(posedge clk); #1;
    end
    bq.push_back(OK);
    hs_aw(32'h8, 3'b001);
    wait_b(lat);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL aw_last_latency: got %0d expected 1", lat);
    end
    do_read(32'h8, 32'h99, OK);
    do_read(32'h4, 32'd1, OK);
  endtask

  task automatic test_prot();
    int lat;
`ifdef WCI_AXI_PROT_CHECK_EN
    bq.push_back(SE);
    rq.push_back({SE, 32'h0});
`else
    bq.push_back(OK);
    rq.push_back({OK, 32'h77});
`endif
    fork
      hs_aw(32'h18, 3'b000);
      hs_w(32'h77, 4'hF);
    join
    wait_b(lat);
    hs_ar(32'h18, 3'b000);
    wait_r(lat);
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_backpressure();
    test_errors();
    test_collision();
    test_mid_reset();
    test_prot();
    repeat (3) @(posedge clk);
    tests++;
    if ((bq.size() + rq.size()) !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               bq.size() + rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
